// File: rtl/stream_qos_pkg.sv
// Shared types and constants for the QoS stream demultiplexer and its output slices.
package stream_qos_pkg;

    // Default beat field widths; the top's width parameters take these as defaults.
    localparam int DATA_W     = 8;
    localparam int QOS_W      = 4;
    localparam int DROP_CNT_W = 16;

    // Packet-routing state of the demultiplexer.
    typedef enum logic [1:0] {
        IDLE,  // next accepted beat starts a packet
        PASS,  // forwarding the rest of a packet to the locked destination
        DROP   // discarding the rest of a packet with an out-of-range id
    } demux_state_t;

    // One stream beat as held by an output slice.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [QOS_W-1:0]  qos;
        logic              last;
    } beat_t;

endpackage

// File: rtl/stream_skid_slice.sv
// Two-entry registered skid slice: the head entry drives the output, the skid entry
// catches the beat accepted while the output is stalled. The upstream ready is a
// flop, so there is no combinational path from the downstream ready back upstream.
module stream_skid_slice
    import stream_qos_pkg::*;
#(
    parameter type slice_beat_t = beat_t
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        push,
    input  slice_beat_t push_beat,
    output logic        rdy,
    output logic        valid,
    input  logic        ready,
    output slice_beat_t beat
);

    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        rdy_q;
    logic        pop;
    slice_beat_t head_q;
    slice_beat_t skid_q;

    assign valid = (count_q != 2'd0);
    assign pop   = valid && ready;
    assign rdy   = rdy_q;
    assign beat  = head_q;

    // Occupancy after this cycle's push/pop; a push is only issued while rdy is high.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        case (count_q)
            2'd0: if (push) count_d = 2'd1;
            2'd1: begin
                if (push && !pop)      count_d = 2'd2;
                else if (!push && pop) count_d = 2'd0;
            end
            default: if (pop) count_d = 2'd1;
        endcase
    end

    // Occupancy, registered not-full flag and the two beat entries.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            rdy_q   <= 1'b1;
            // NOTE: the data entries are reset too, because the outputs must read as zero straight out of reset.
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            count_q <= count_d;
            rdy_q   <= (count_d != 2'd2);
            if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                head_q <= push_beat;
            end else if (pop && (count_q == 2'd2)) begin
                head_q <= skid_q;
            end
            if (push && (count_q == 2'd1) && !pop) begin
                skid_q <= push_beat;
            end
        end
    end

endmodule

// File: rtl/stream_demux_qos.sv
// Packet-aware 1-to-N stream demultiplexer: routes each packet, whole and in order,
// to the output named by the id of its first beat; packets with an out-of-range id
// are swallowed and counted.
module stream_demux_qos
    import stream_qos_pkg::*;
#(
    parameter int T_DATA_WIDTH = DATA_W,
    parameter int T_QOS__WIDTH = QOS_W,
    parameter int STREAM_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_n,
    input  logic [T_DATA_WIDTH-1:0]                  s_data_i,
    input  logic [T_QOS__WIDTH-1:0]                  s_qos_i,
    input  logic [T_ID___WIDTH-1:0]                  s_id_i,
    input  logic                                     s_last_i,
    input  logic                                     s_valid_i,
    output logic                                     s_ready_o,
    output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
    output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] m_qos_o,
    output logic [STREAM_COUNT-1:0]                  m_last_o,
    output logic [STREAM_COUNT-1:0]                  m_valid_o,
    input  logic [STREAM_COUNT-1:0]                  m_ready_i,
    output logic [DROP_CNT_W-1:0]                    drop_cnt_o
);

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic [T_QOS__WIDTH-1:0] qos;
        logic                    last;
    } lane_beat_t;

    demux_state_t            state_q;
    demux_state_t            state_d;
    logic [T_ID___WIDTH-1:0] dest_q;
    logic [T_ID___WIDTH-1:0] dest_d;
    logic [T_ID___WIDTH-1:0] route_id;
    logic                    route_en;
    logic                    drop_inc;
    logic                    id_in_range;
    logic [DROP_CNT_W-1:0]   drop_cnt_q;
    logic [STREAM_COUNT-1:0] slice_rdy;
    logic [STREAM_COUNT-1:0] push;
    lane_beat_t              in_beat;
    lane_beat_t              out_beat [STREAM_COUNT];

    assign id_in_range = (int'(s_id_i) < STREAM_COUNT);
    assign in_beat     = '{data: s_data_i, qos: s_qos_i, last: s_last_i};
    assign drop_cnt_o  = drop_cnt_q;

    // Routing state, locked destination and saturating drop counter.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dest_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            if (drop_inc && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end
        end
    end

    // Next state, input ready and beat routing; ready only looks at registered slice flags.
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        s_ready_o = 1'b1;
        route_en  = 1'b0;
        route_id  = dest_q;
        drop_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                route_id = s_id_i;
                if (id_in_range) begin
                    s_ready_o = slice_rdy[s_id_i];
                    if (s_valid_i && slice_rdy[s_id_i]) begin
                        route_en = 1'b1;
                        if (!s_last_i) begin
                            state_d = PASS;
                            dest_d  = s_id_i;
                        end
                    end
                end else if (s_valid_i) begin
                    drop_inc = 1'b1;
                    if (!s_last_i) state_d = DROP;
                end
            end
            PASS: begin
                s_ready_o = slice_rdy[dest_q];
                if (s_valid_i && slice_rdy[dest_q]) begin
                    route_en = 1'b1;
                    if (s_last_i) state_d = IDLE;
                end
            end
            DROP: begin
                if (s_valid_i && s_last_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < STREAM_COUNT; k++) begin : g_lane
        assign push[k] = route_en && (route_id == T_ID___WIDTH'(k));

        stream_skid_slice #(
            .slice_beat_t(lane_beat_t)
        ) u_slice (
            .clk_i    (clk_i),
            .rst_n    (rst_n),
            .push     (push[k]),
            .push_beat(in_beat),
            .rdy      (slice_rdy[k]),
            .valid    (m_valid_o[k]),
            .ready    (m_ready_i[k]),
            .beat     (out_beat[k])
        );

        assign m_data_o[k] = out_beat[k].data;
        assign m_qos_o[k]  = out_beat[k].qos;
        assign m_last_o[k] = out_beat[k].last;
    end

endmodule
